// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-memory sequencer.
//   - MemDataType codes (byte/half/word; 2'b11 is reserved)
//   - sequencer state encoding
//   - little-endian lane-select helpers and the alignment check
package mem_pkg;

  localparam logic [1:0] MDT_BYTE = 2'b00;
  localparam logic [1:0] MDT_HALF = 2'b01;
  localparam logic [1:0] MDT_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_RMW_WRITE = 2'd2
  } state_e;

  // Byte lane k occupies bits [8k+7:8k].
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Half lane h occupies bits [16h+15:16h].
  function automatic logic [15:0] lane_half(input logic [31:0] w, input logic h);
    return h ? w[31:16] : w[15:0];
  endfunction

  // True for a reserved type or an access not aligned to its own size.
  function automatic logic bad_access(input logic [1:0] dtype, input logic [1:0] off);
    logic bad;
    case (dtype)
      MDT_BYTE: bad = 1'b0;
      MDT_HALF: bad = off[0];
      MDT_WORD: bad = (off != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: combinational lane logic for the data-memory sequencer.
//   word_i    : word read from RAM
//   data_i    : store data (low byte/half used for sb/sh)
//   dtype_i   : MemDataType
//   offset_i  : Address[1:0]
//   merged_o  : word_i with the selected lane replaced by data_i (store merge)
//   loaded_o  : selected lane of word_i, sign-extended to 32 bits (load extract)
module byte_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  dtype_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] merged_o,
  output logic [31:0] loaded_o
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    merged_o = word_i;
    case (dtype_i)
      MDT_BYTE: begin
        case (offset_i)
          2'd0:    merged_o[7:0]   = data_i[7:0];
          2'd1:    merged_o[15:8]  = data_i[7:0];
          2'd2:    merged_o[23:16] = data_i[7:0];
          default: merged_o[31:24] = data_i[7:0];
        endcase
      end
      MDT_HALF: begin
        if (offset_i[1]) merged_o[31:16] = data_i[15:0];
        else             merged_o[15:0]  = data_i[15:0];
      end
      default: merged_o = data_i;
    endcase
  end

  always_comb begin
    sel_b = lane_byte(word_i, offset_i);
    sel_h = lane_half(word_i, offset_i[1]);
    case (dtype_i)
      MDT_BYTE: loaded_o = {{24{sel_b[7]}}, sel_b};
      MDT_HALF: loaded_o = {{16{sel_h[15]}}, sel_h};
      default:  loaded_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage sequencer turning lb/lh/lw/sb/sh/sw into
// accesses on a 32-bit single-port synchronous RAM.
//   Clk, Rst              : clock, synchronous active-high reset
//   MemRead, MemWrite     : load / store request
//   MemDataType           : 00 byte, 01 half, 10 word, 11 reserved
//   Address, WriteData    : byte address, store data
//   ReadData              : sign-extended load result (held between loads)
//   Stall                 : request inputs must stay stable while high
//   Done, AddrError       : single-cycle completion / rejection pulses
//   ram_addr, ram_we, ram_wdata, ram_rdata : RAM port (1-cycle read latency)
// sw completes in one cycle; loads and sb/sh take two (read, then use).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned RAM_AW = 10
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemDataType,
  input  logic [31:0]       Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              Done,
  output logic              AddrError,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_e      state_q, state_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] merged, loaded;
  logic        req, reject;

  // Address bits above the RAM window are ignored (accesses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^Address[31:RAM_AW+2];

  assign req    = MemRead | MemWrite;
  assign reject = (MemRead & MemWrite) | bad_access(MemDataType, Address[1:0]);

  byte_lane_merge u_lanes (
    .word_i   (ram_rdata),
    .data_i   (WriteData),
    .dtype_i  (MemDataType),
    .offset_i (Address[1:0]),
    .merged_o (merged),
    .loaded_o (loaded)
  );

  // Second-cycle work uses the live request inputs: they are held stable
  // while Stall is high, so nothing is captured on entry.
  always_comb begin
    state_d    = state_q;
    readdata_d = readdata_q;
    ReadData   = readdata_q;
    Stall      = 1'b0;
    Done       = 1'b0;
    AddrError  = 1'b0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    ram_addr   = Address[RAM_AW+1:2];
    if (Rst) begin
      state_d    = ST_IDLE;
      readdata_d = '0;
      ReadData   = '0;
      ram_addr   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (reject) begin
              AddrError = 1'b1;
            end else if (MemWrite && MemDataType == MDT_WORD) begin
              ram_we    = 1'b1;
              ram_wdata = WriteData;
              Done      = 1'b1;
            end else if (MemRead) begin
              Stall   = 1'b1;
              state_d = ST_LOAD_WAIT;
            end else begin
              Stall   = 1'b1;
              state_d = ST_RMW_WRITE;
            end
          end
        end
        ST_LOAD_WAIT: begin
          readdata_d = loaded;
          ReadData   = loaded;
          Done       = 1'b1;
          state_d    = ST_IDLE;
        end
        ST_RMW_WRITE: begin
          ram_we    = 1'b1;
          ram_wdata = merged;
          Done      = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios then random traffic, checked
// against a byte-addressed reference memory (4 KB, little-endian).
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemRead, MemWrite;
  logic [1:0]  MemDataType;
  logic [31:0] Address, WriteData;
  logic [31:0] ReadData;
  logic        Stall, Done, AddrError;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  always #5 Clk = ~Clk;

  mem_access_unit #(.RAM_AW(10)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemDataType (MemDataType),
    .Address     (Address),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .Stall       (Stall),
    .Done        (Done),
    .AddrError   (AddrError),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  // Physical RAM attached to the DUT: synchronous read, read-before-write.
  logic [31:0] ram [0:1023];
  always @(posedge Clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // Reference: plain byte array, updated by the bench from each request.
  logic [7:0]  ref_b [0:4095];
  logic [31:0] exp_rd;
  int          nassert = 0;
  int          nfail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int unsigned a);
    int unsigned w;
    w = a & 32'hFFC;
    return {ref_b[w+3], ref_b[w+2], ref_b[w+1], ref_b[w]};
  endfunction

  // Inputs must not move during a stall cycle.
  logic [67:0] saved_in;
  bit          was_stall = 1'b0;
  always @(negedge Clk) begin
    #3;
    if (was_stall) begin
      nassert++;
      assert ({MemRead, MemWrite, MemDataType, Address, WriteData} === saved_in) else begin
        nfail++;
        $error("FAIL inputs_stable: observed=%h expected=%h",
               {MemRead, MemWrite, MemDataType, Address, WriteData}, saved_in);
      end
    end
    was_stall = (Stall === 1'b1);
    saved_in  = {MemRead, MemWrite, MemDataType, Address, WriteData};
  end

  task automatic check_reset_outputs(input string tag);
    check(tag, ReadData, 32'h0);
    check1(tag, Stall, 1'b0);
    check1(tag, Done, 1'b0);
    check1(tag, AddrError, 1'b0);
    check1(tag, ram_we, 1'b0);
    check(tag, ram_wdata, 32'h0);
    check(tag, 32'(ram_addr), 32'h0);
  endtask

  // One request, from its first cycle through completion, no gap afterwards.
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] dt,
                       input logic [31:0] addr, input logic [31:0] wd);
    int unsigned a;
    bit          err;
    logic [31:0] exp;
    a = addr & 32'hFFF;
    @(negedge Clk);
    MemRead = rd; MemWrite = wr; MemDataType = dt; Address = addr; WriteData = wd;
    #1;
    if (!rd && !wr) begin
      check1("idle_stall", Stall, 1'b0);
      check1("idle_done", Done, 1'b0);
      check1("idle_we", ram_we, 1'b0);
      check1("idle_err", AddrError, 1'b0);
      check("idle_readdata", ReadData, exp_rd);
      return;
    end
    err = (rd && wr) || dt == 2'b11 || (dt == 2'b01 && a % 2 != 0) || (dt == 2'b10 && a % 4 != 0);
    if (err) begin
      check1("err_pulse", AddrError, 1'b1);
      check1("err_stall", Stall, 1'b0);
      check1("err_done", Done, 1'b0);
      check1("err_we", ram_we, 1'b0);
      check("err_readdata", ReadData, exp_rd);
      return;
    end
    check("ram_addr", 32'(ram_addr), (addr >> 2) & 32'd1023);
    check1("no_err", AddrError, 1'b0);
    if (wr && dt == 2'b10) begin
      for (int i = 0; i < 4; i++) ref_b[a + i] = wd[8*i +: 8];
      check1("sw_we", ram_we, 1'b1);
      check("sw_wdata", ram_wdata, wd);
      check1("sw_done", Done, 1'b1);
      check1("sw_stall", Stall, 1'b0);
      check("sw_readdata", ReadData, exp_rd);
      return;
    end
    check1("first_stall", Stall, 1'b1);
    check1("first_done", Done, 1'b0);
    check1("first_we", ram_we, 1'b0);
    @(negedge Clk);
    #1;
    check1("second_stall", Stall, 1'b0);
    check1("second_done", Done, 1'b1);
    if (rd) begin
      case (dt)
        2'b00:   exp = {{24{ref_b[a][7]}}, ref_b[a]};
        2'b01:   exp = {{16{ref_b[a+1][7]}}, ref_b[a+1], ref_b[a]};
        default: exp = ref_word(a);
      endcase
      exp_rd = exp;
      check("load_data", ReadData, exp);
      check1("load_we", ram_we, 1'b0);
    end else begin
      ref_b[a] = wd[7:0];
      if (dt == 2'b01) ref_b[a + 1] = wd[15:8];
      check1("rmw_we", ram_we, 1'b1);
      check("rmw_wdata", ram_wdata, ref_word(a));
      check("rmw_addr", 32'(ram_addr), (addr >> 2) & 32'd1023);
    end
  endtask

  initial begin
    logic [31:0] w;
    int          bad_words;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      ram[i] = w;
      for (int j = 0; j < 4; j++) ref_b[4*i + j] = w[8*j +: 8];
    end
    exp_rd = 32'h0;

    // Power-on reset with a nonzero address on the bus.
    Rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemDataType = 2'b10;
    Address = 32'hFFFF_FFFC; WriteData = 32'h1234_5678;
    repeat (2) begin
      @(negedge Clk); #1;
      check_reset_outputs("por");
    end
    @(negedge Clk); Rst = 1'b0;

    // Word store, then loads of its lanes.
    do_op(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF);
    do_op(1'b1, 1'b0, 2'b00, 32'h11, 32'h0);
    check("lb_literal", ReadData, 32'hFFFF_FFBE);
    do_op(1'b1, 1'b0, 2'b01, 32'h12, 32'h0);
    check("lh_literal", ReadData, 32'hFFFF_DEAD);
    do_op(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    check("lw_literal", ReadData, 32'hDEAD_BEEF);

    // Sub-word read-modify-write stores.
    do_op(1'b0, 1'b1, 2'b00, 32'h13, 32'h0000_00AA);
    check("sb_merge_literal", ref_word(32'h10), 32'hAAAD_BEEF);
    do_op(1'b0, 1'b1, 2'b01, 32'h10, 32'h0000_1234);
    do_op(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    check("sh_merge_literal", ReadData, 32'hAAAD_1234);

    // Rejected requests.
    do_op(1'b1, 1'b0, 2'b01, 32'h11, 32'h0);
    do_op(1'b1, 1'b0, 2'b10, 32'h12, 32'h0);
    do_op(1'b1, 1'b0, 2'b11, 32'h10, 32'h0);
    do_op(1'b1, 1'b1, 2'b10, 32'h10, 32'h5555_5555);
    do_op(1'b0, 1'b1, 2'b01, 32'h21, 32'hFFFF_FFFF);
    do_op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

    // Reset asserted in the write cycle of an sb: the write must not happen.
    @(negedge Clk);
    MemRead = 1'b0; MemWrite = 1'b1; MemDataType = 2'b00; Address = 32'h33; WriteData = 32'h77;
    #1;
    check1("rst_rmw_first_stall", Stall, 1'b1);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_rmw");
    @(negedge Clk);
    MemWrite = 1'b0; Address = 32'h44;
    #1;
    check_reset_outputs("rst_hold");
    @(negedge Clk);
    Rst = 1'b0;
    exp_rd = 32'h0;
    #1;
    check("rst_readdata_cleared", ReadData, 32'h0);
    // Single-cycle sw proves the sequencer is back in IDLE.
    do_op(1'b0, 1'b1, 2'b10, 32'h40, 32'h0BAD_F00D);

    // Back-to-back load, byte store, byte load.
    do_op(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
    do_op(1'b0, 1'b1, 2'b00, 32'h21, 32'h0000_0080);
    do_op(1'b1, 1'b0, 2'b00, 32'h21, 32'h0);
    check("b2b_lb_literal", ReadData, 32'hFFFF_FF80);

    // Random traffic, including addresses above the 4 KB window.
    for (int n = 0; n < 300; n++) begin
      logic        rd, wr;
      logic [1:0]  dt;
      logic [31:0] addr;
      int unsigned kind;
      kind = $urandom_range(0, 19);
      rd   = (kind < 9) || (kind == 19);
      wr   = (kind >= 9 && kind < 18) || (kind == 19);
      dt   = (kind % 7 == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
      addr = $urandom & 32'hFFFF_F03F;
      if ($urandom_range(0, 3) != 0) begin
        if (dt == 2'b01) addr[0] = 1'b0;
        if (dt == 2'b10) addr[1:0] = 2'b00;
      end
      do_op(rd, wr, dt, addr, $urandom);
    end

    do_op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (2) @(negedge Clk);
    bad_words = 0;
    for (int i = 0; i < 1024; i++)
      if (ram[i] !== ref_word(4 * i)) bad_words++;
    check("ram_contents_bad_words", 32'(bad_words), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
